apmu_instr_mem_responder: RTL and testbench

- Responder end of the instruction-fetch bus (req/gnt/addr → rvalid/rdata/err) that the core's prefetch buffer drives.
- Accepts pipelined, in-order fetch requests and converts them to reads on a single-port synchronous SRAM macro with 1-cycle read latency.
- Returns responses at a fixed, configurable latency, caps in-flight requests, and flags out-of-range addresses as bus errors.
- Used as the instruction memory in the APMU subsystem and as the fetch-side model in core-level benches.

---
 rtl/apmu_instr_mem_responder.sv | 117 +++++++++++
 tb/tb_apmu_instr_mem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/apmu_instr_mem_responder.sv
// apmu_instr_mem_responder: responder end of the instruction-fetch bus.
// Turns granted fetches into reads on a 1-cycle-latency synchronous SRAM.
// Answers each fetch in grant order, a fixed Latency cycles after its grant.
// Limits the number of fetches in flight to MaxOutstanding.
// Returns a bus error for any address outside the memory window.
module apmu_instr_mem_responder #(
   parameter logic [31:0] AddrBase       = 32'h0000_0000,
   parameter int unsigned MemWords       = 4096,
   parameter int unsigned Latency        = 2,
   parameter int unsigned MaxOutstanding = 2,
   localparam int unsigned AW            = $clog2(MemWords),
   localparam int unsigned CW            = $clog2(MaxOutstanding + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          instr_req_i,
   output logic          instr_gnt_o,
   input  logic [31:0]   instr_addr_i,
   output logic          instr_rvalid_o,
   output logic [31:0]   instr_rdata_o,
   output logic          instr_err_o,
   input  logic          stall_i,
   output logic          mem_req_o,
   output logic [AW-1:0] mem_addr_o,
   input  logic [31:0]   mem_rdata_i,
   output logic [CW-1:0] outstanding_o,
   output logic          busy_o
);

   // Window size in bytes, one bit wider so the largest windows still compare correctly.
   localparam logic [32:0]   WindowBytes = 33'(MemWords) << 2;
   localparam logic [CW-1:0] MaxCount    = CW'(MaxOutstanding);
   localparam int unsigned   HeadIdx     = Latency - 1;

   if (Latency < 1 || Latency > 8) begin : g_bad_latency
      $error("apmu_instr_mem_responder: Latency must be in 1..8");
   end
   if (MaxOutstanding < 1 || MaxOutstanding > Latency) begin : g_bad_max_outstanding
      $error("apmu_instr_mem_responder: MaxOutstanding must be in 1..Latency");
   end

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] data;
   } stage_t;

   stage_t        pipe_q [Latency];
   stage_t        fill_stage;
   stage_t        head;
   logic [CW-1:0] count_q;
   logic [31:0]   offset;
   logic          in_range;
   logic          gnt;
   logic          rvalid;

   // Range check of the requested address.
   // Addresses below AddrBase wrap to large offsets and fall outside the window.
   always_comb begin
      offset   = instr_addr_i - AddrBase;
      in_range = {1'b0, offset} < WindowBytes;
   end

   // Grant depends only on registered state, never on this cycle's response.
   assign gnt         = instr_req_i & ~stall_i & ~rst_i & (count_q < MaxCount);
   assign instr_gnt_o = gnt;
   assign mem_req_o   = gnt & in_range;
   assign mem_addr_o  = offset[AW+1:2];

   // Stage 0 picks up the SRAM read data one cycle after its grant.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      fill_stage = pipe_q[0];
      if (pipe_q[0].valid && !pipe_q[0].err) begin
         fill_stage.data = mem_rdata_i;
      end
   end

   // With Latency=1 the response leaves in the same cycle the SRAM data arrives.
   assign head           = (Latency == 1) ? fill_stage : pipe_q[HeadIdx];
   assign rvalid         = head.valid & ~rst_i;
   assign instr_rvalid_o = rvalid;
   assign instr_err_o    = rvalid & head.err;
   assign instr_rdata_o  = rvalid ? head.data : '0;

   // Response pipeline: load on grant, shift every cycle, flush on reset.
   // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(Latency); i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= stage_t'{valid: gnt, err: gnt & ~in_range, data: '0};
         for (int i = 1; i < int'(Latency); i++) begin
            pipe_q[i] <= (i == 1) ? fill_stage : pipe_q[i-1];
         end
      end
   end

   // In-flight counter: increments on each grant and decrements on each response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CW'(gnt) - CW'(rvalid);
      end
   end

   assign outstanding_o = count_q;
   assign busy_o        = |count_q;

   // A response must always belong to a fetch that was counted as in flight.
   a_rvalid_needs_count : assert property (@(posedge clk_i) disable iff (rst_i)
      instr_rvalid_o |-> (count_q != '0));

endmodule

// File: tb/tb_apmu_instr_mem_responder.sv
// Self-checking bench for apmu_instr_mem_responder.
// The reference model is a queue of promised responses, each with its due cycle.
// An SRAM model returns read data one cycle after each read.
module tb_apmu_instr_mem_responder;

   localparam logic [31:0] BASE    = 32'h0000_1000;
   localparam int          WORDS   = 256;
   localparam int          LAT     = 3;
   localparam int          MAX_OUT = 2;
   localparam logic [31:0] WIN     = 32'(WORDS * 4);

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
   } resp_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        instr_req_i;
   logic        instr_gnt_o;
   logic [31:0] instr_addr_i;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_err_o;
   logic        stall_i;
   logic        mem_req_o;
   logic [7:0]  mem_addr_o;
   logic [31:0] mem_rdata_i;
   logic [1:0]  outstanding_o;
   logic        busy_o;

   logic [31:0] mem [WORDS];
   resp_t       inflight [$];
   int          cyc;
   int          n_vec;
   int          n_err;
   logic        last_gnt;
   logic        sram_rd;
   logic [7:0]  sram_addr;

   apmu_instr_mem_responder #(
      .AddrBase       (BASE),
      .MemWords       (WORDS),
      .Latency        (LAT),
      .MaxOutstanding (MAX_OUT)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .instr_req_i    (instr_req_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_addr_i   (instr_addr_i),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .instr_err_o    (instr_err_o),
      .stall_i        (stall_i),
      .mem_req_o      (mem_req_o),
      .mem_addr_o     (mem_addr_o),
      .mem_rdata_i    (mem_rdata_i),
      .outstanding_o  (outstanding_o),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   // One clock cycle. It is entered 1 time unit after a rising edge, with inputs already driven.
   // It checks the outputs mid-cycle, advances the model, then crosses the next edge.
   task automatic cycle();
      logic [31:0] off;
      logic        in_rng;
      logic        exp_gnt;
      logic        exp_rv;
      resp_t       hd;
      #3;
      off     = instr_addr_i - BASE;
      in_rng  = off < WIN;
      exp_gnt = instr_req_i && !stall_i && !rst_i && (inflight.size() < MAX_OUT);
      exp_rv  = !rst_i && (inflight.size() > 0) && (inflight[0].due == cyc);
      hd      = exp_rv ? inflight[0] : resp_t'{due: 0, err: 1'b0, data: 32'h0};
      cmp("gnt", 32'(instr_gnt_o), 32'(exp_gnt));
      cmp("mem_req", 32'(mem_req_o), 32'(exp_gnt && in_rng));
      if (exp_gnt && in_rng) cmp("mem_addr", 32'(mem_addr_o), 32'(off[9:2]));
      cmp("rvalid", 32'(instr_rvalid_o), 32'(exp_rv));
      cmp("err", 32'(instr_err_o), 32'(hd.err));
      cmp("rdata", instr_rdata_o, hd.data);
      if (!rst_i) begin
         cmp("outstanding", 32'(outstanding_o), 32'(inflight.size()));
         cmp("busy", 32'(busy_o), 32'(inflight.size() != 0));
      end
      if (rst_i) begin
         inflight.delete();
      end else begin
         if (exp_rv) void'(inflight.pop_front());
         if (exp_gnt) inflight.push_back(resp_t'{due: cyc + LAT, err: !in_rng,
                                                 data: in_rng ? mem[off[9:2]] : 32'h0});
      end
      last_gnt  = exp_gnt;
      sram_rd   = mem_req_o;
      sram_addr = mem_addr_o;
      @(posedge clk_i);
      cyc++;
      #1;
      mem_rdata_i = sram_rd ? mem[sram_addr] : $urandom();
   endtask

   task automatic idle(input int n);
      instr_req_i = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Holds the request at one address until the model says it was granted.
   task automatic fetch(input logic [31:0] a);
      logic done;
      done         = 1'b0;
      instr_req_i  = 1'b1;
      instr_addr_i = a;
      for (int i = 0; i < 16 && !done; i++) begin
         cycle();
         done = last_gnt;
      end
      cmp("grant_within_bound", 32'(done), 32'd1);
      instr_req_i = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      n_vec = 0;
      n_err = 0;
      cyc   = 0;
      for (int i = 0; i < WORDS; i++) mem[i] = $urandom();
      mem[16]      = 32'hDEAD_BEEF;
      rst_i        = 1'b1;
      instr_req_i  = 1'b0;
      instr_addr_i = 32'h0;
      stall_i      = 1'b0;
      mem_rdata_i  = $urandom();
      @(posedge clk_i);
      #1;

      // Reset held for two cycles, with a request present that must not be granted.
      instr_req_i  = 1'b1;
      instr_addr_i = BASE;
      cycle();
      cycle();
      rst_i       = 1'b0;
      instr_req_i = 1'b0;
      idle(1);

      // Single fetch of word 0x10.
      fetch(BASE + 32'h40);
      idle(LAT + 1);

      // Streaming: eight sequential fetches with the request held continuously.
      for (int i = 0; i < 8; i++) fetch(BASE + 32'(i * 4));
      idle(LAT + 1);

      // Below the window, just past the window, and the last word of the window.
      fetch(32'h0000_0FFC);
      fetch(32'h0000_1400);
      fetch(32'h0000_13FC);
      idle(LAT + 1);

      // Stall for three cycles while a request is held, then release it.
      instr_req_i  = 1'b1;
      instr_addr_i = BASE + 32'h8;
      stall_i      = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      stall_i = 1'b0;
      fetch(BASE + 32'h8);
      idle(LAT + 1);

      // Reset in the middle of two in-flight fetches, then a fresh fetch.
      fetch(BASE + 32'h4);
      fetch(BASE + 32'hC);
      rst_i = 1'b1;
      cycle();
      rst_i = 1'b0;
      fetch(BASE + 32'h44);
      idle(LAT + 2);

      // Random traffic: requests, stalls, occasional resets, and both in- and out-of-window addresses.
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 7))
            0:       a = BASE - 32'($urandom_range(1, 16) * 4);
            1:       a = BASE + WIN + 32'($urandom_range(0, 255));
            default: a = BASE + (32'($urandom_range(0, WORDS - 1)) << 2) + 32'($urandom_range(0, 3));
         endcase
         instr_addr_i = a;
         instr_req_i  = ($urandom_range(0, 3) != 0);
         stall_i      = ($urandom_range(0, 7) == 0);
         rst_i        = ($urandom_range(0, 63) == 0);
         cycle();
      end
      rst_i   = 1'b0;
      stall_i = 1'b0;
      idle(LAT + 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
